// File: rtl/risc_v_pkg.sv
// Shared ALU-control encodings for the decode/execute boundary.
// Operation is {Ainvert, Binvert, Op[1:0]} as consumed by the ripple ALU.
package risc_v_pkg;

    typedef enum logic [1:0] {
        ALUOP_LDST  = 2'b00,
        ALUOP_BR    = 2'b01,
        ALUOP_ARITH = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control: maps alu_op/funct3/funct7[5] to the 4-bit Operation.
// Unsupported encodings fall back to ADD and raise o_illegal.
module alu_ctrl_decode
    import risc_v_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    input  logic       i_is_rtype,
    output logic [3:0] o_operation,
    output logic       o_illegal
);

    always_comb begin
        o_operation = ALU_ADD;
        o_illegal   = 1'b0;
        case (alu_op_e'(i_alu_op))
            ALUOP_LDST: o_operation = ALU_ADD;
            ALUOP_BR:   o_operation = ALU_SUB;
            ALUOP_ARITH: begin
                case (i_funct3)
                    // funct7_b5 is an immediate bit for I-type, so only R-type may select SUB
                    F3_ADD:  o_operation = (i_is_rtype && i_funct7_b5) ? ALU_SUB : ALU_ADD;
                    F3_AND:  o_operation = ALU_AND;
                    F3_OR:   o_operation = ALU_OR;
                    F3_SLT:  o_operation = ALU_SLT;
                    default: o_illegal   = 1'b1;
                endcase
            end
            ALUOP_RSVD: o_illegal = 1'b1;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: single-entry valid/ready buffer holding
// ALU operands and control, with flush and a saturating stall counter.
module id_ex_stage
    import risc_v_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [N-1:0]     rs1_data,
    input  logic [N-1:0]     rs2_data,
    input  logic [N-1:0]     imm,
    input  logic             alu_src,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    input  logic             is_rtype,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_operation,
    output logic [4:0]       rd_out,
    output logic             reg_write_out,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [3:0]       w_operation;
    logic             w_illegal;
    logic [N-1:0]     w_b;
    logic             w_in_ready;
    logic             w_load;
    logic             w_stall;

    logic             r_out_valid;
    logic [N-1:0]     r_alu_a;
    logic [N-1:0]     r_alu_b;
    logic [3:0]       r_alu_operation;
    logic [4:0]       r_rd;
    logic             r_reg_write;
    logic             r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    alu_ctrl_decode u_decode (
        .i_alu_op    (alu_op),
        .i_funct3    (funct3),
        .i_funct7_b5 (funct7_b5),
        .i_is_rtype  (is_rtype),
        .o_operation (w_operation),
        .o_illegal   (w_illegal)
    );

    assign w_b        = alu_src ? imm : rs2_data;
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_load     = in_valid && w_in_ready && !flush;
    assign w_stall    = r_out_valid && !out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_alu_operation <= '0;
            r_rd            <= '0;
            r_reg_write     <= 1'b0;
            r_illegal       <= 1'b0;
            r_stall_cnt     <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Payload only moves on an accepted load, so it is naturally held under backpressure
            if (w_load) begin
                r_alu_a         <= rs1_data;
                r_alu_b         <= w_b;
                r_alu_operation <= w_operation;
                r_rd            <= rd_in;
                r_reg_write     <= reg_write_in && !w_illegal;
                r_illegal       <= w_illegal;
            end

            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_operation = r_alu_operation;
    assign rd_out        = r_rd;
    assign reg_write_out = r_reg_write;
    assign illegal_op    = r_illegal;
    assign stall_cnt     = r_stall_cnt;

endmodule
